// File: rtl/btn_debounce_ctrl_pkg.sv
// Shared definitions for the pushbutton conditioner: per-channel FSM encoding
// and default synchronizer / debounce depths.
package btn_debounce_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_debounce_ctrl_ch.sv
// One debounce channel: synchronizer chain, press/release FSM with a stability
// counter, registered one-cycle press strobe and registered held level.
module debounce_ch
  import btn_debounce_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw_n,
  output logic o_strobe_n,
  output logic o_held_n
);

  localparam logic [CNT_W-1:0] LP_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_strobe_n;
  logic                   r_held_n;

  db_state_e              w_nxt_state;
  logic [CNT_W-1:0]       w_nxt_cnt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_fire;
  logic                   w_s;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + LP_ONE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync     <= '1;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_strobe_n <= 1'b1;
      r_held_n   <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_raw_n};
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_strobe_n <= ~w_fire;
      // Held tracks the next state so it falls on the same edge as the strobe.
      r_held_n   <= ~((w_nxt_state == ST_HELD) || (w_nxt_state == ST_RELEASE_WAIT));
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_s) begin
          w_nxt_state = ST_PRESS_WAIT;
          w_nxt_cnt   = LP_ONE;
        end else begin
          w_nxt_cnt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_s) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end else if (w_cnt_inc == LP_DONE) begin
          w_nxt_state = ST_HELD;
          w_nxt_cnt   = '0;
          w_fire      = 1'b1;
        end else begin
          w_nxt_cnt   = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (w_s) begin
          w_nxt_state = ST_RELEASE_WAIT;
          w_nxt_cnt   = LP_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_s) begin
          w_nxt_state = ST_HELD;
          w_nxt_cnt   = '0;
        end else if (w_cnt_inc == LP_DONE) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt   = w_cnt_inc;
        end
      end
    endcase
  end

  assign o_strobe_n = r_strobe_n;
  assign o_held_n   = r_held_n;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Two independent debounce channels feeding the set/reset flip-flop controls.
module btn_debounce_ctrl
  import btn_debounce_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_set_raw_n,
  input  logic btn_reset_raw_n,
  output logic ff_set_n,
  output logic ff_reset_n,
  output logic set_held_n,
  output logic reset_held_n
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_ch (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_raw_n   (btn_set_raw_n),
    .o_strobe_n(ff_set_n),
    .o_held_n  (set_held_n)
  );

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_reset_ch (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_raw_n   (btn_reset_raw_n),
    .o_strobe_n(ff_reset_n),
    .o_held_n  (reset_held_n)
  );

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Scoreboard bench: stimulus queues expected strobe/held events with their edge
// number; a negedge monitor matches every observed event against the queue.
module tb_btn_debounce_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic sraw [2];
  logic rraw [2];
  logic o_set [2];
  logic o_rst [2];
  logic o_sh  [2];
  logic o_rh  [2];

  always #5 clk = ~clk;

  // dut 0: defaults (sync 2, debounce 4) -> latency 6 from drive negedge
  btn_debounce_ctrl dut0 (
    .clk(clk), .reset_n(reset_n),
    .btn_set_raw_n(sraw[0]), .btn_reset_raw_n(rraw[0]),
    .ff_set_n(o_set[0]), .ff_reset_n(o_rst[0]),
    .set_held_n(o_sh[0]), .reset_held_n(o_rh[0])
  );

  // dut 1: sync 3, debounce 2 -> latency 5 from drive negedge
  btn_debounce_ctrl #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .btn_set_raw_n(sraw[1]), .btn_reset_raw_n(rraw[1]),
    .ff_set_n(o_set[1]), .ff_reset_n(o_rst[1]),
    .set_held_n(o_sh[1]), .reset_held_n(o_rh[1])
  );

  typedef struct {
    int dut;
    int ch;
    int kind;   // 0 strobe low, 1 held level change
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  logic prev_sh [2];
  logic prev_rh [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int d, input int c, input int k, input int v, input int t);
    ev_t e;
    e.dut = d; e.ch = c; e.kind = k; e.val = v; e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic see(input int d, input int c, input int k, input int v);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].dut == d && exp_q[i].ch == c && exp_q[i].kind == k) begin
        idx = i;
        break;
      end
    end
    n_chk++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL unexpected_event dut%0d ch%0d kind%0d: got val %0d at edge %0d, required no event",
               d, c, k, v, cyc);
    end else begin
      if (exp_q[idx].cyc != cyc || exp_q[idx].val != v) begin
        n_fail++;
        $display("FAIL event_timing dut%0d ch%0d kind%0d: got val %0d at edge %0d, required val %0d at edge %0d",
                 d, c, k, v, cyc, exp_q[idx].val, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!mon_en) begin
        prev_sh[d] <= 1'b1;
        prev_rh[d] <= 1'b1;
      end else begin
        if (!o_set[d])          see(d, 0, 0, 0);
        if (o_sh[d] != prev_sh[d]) see(d, 0, 1, int'(o_sh[d]));
        if (!o_rst[d])          see(d, 1, 0, 0);
        if (o_rh[d] != prev_rh[d]) see(d, 1, 1, int'(o_rh[d]));
        prev_sh[d] <= o_sh[d];
        prev_rh[d] <= o_rh[d];
      end
    end
  end

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string nm, input logic act);
    n_chk++;
    if (act !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got %b, required 1", nm, act);
    end
  endtask

  initial begin
    int k;
    int bp [8];
    bp = '{0, 0, 0, 1, 0, 0, 1, 1};
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sraw[d] = 1'b0;
      rraw[d] = 1'b0;
    end
    tk(3);
    for (int d = 0; d < 2; d++) begin
      chk1($sformatf("reset_ff_set_n_dut%0d", d), o_set[d]);
      chk1($sformatf("reset_ff_reset_n_dut%0d", d), o_rst[d]);
      chk1($sformatf("reset_set_held_n_dut%0d", d), o_sh[d]);
      chk1($sformatf("reset_reset_held_n_dut%0d", d), o_rh[d]);
    end
    mon_en = 1'b1;

    // Reset released with both buttons still pressed
    k = cyc;
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        ex(d, c, 0, 0, k + (d == 0 ? 6 : 5));
        ex(d, c, 1, 0, k + (d == 0 ? 6 : 5));
      end
    end
    tk(10);
    k = cyc;
    for (int d = 0; d < 2; d++) begin
      sraw[d] = 1'b1;
      rraw[d] = 1'b1;
      ex(d, 0, 1, 1, k + (d == 0 ? 6 : 5));
      ex(d, 1, 1, 1, k + (d == 0 ? 6 : 5));
    end
    tk(12);

    // Clean press held 20 cycles: exactly one strobe
    k = cyc;
    sraw[0] = 1'b0;
    ex(0, 0, 0, 0, k + 6);
    ex(0, 0, 1, 0, k + 6);
    tk(20);
    k = cyc;
    sraw[0] = 1'b1;
    ex(0, 0, 1, 1, k + 6);
    tk(10);

    // Bounce on reset button: never stable for 4 samples
    for (int i = 0; i < 8; i++) begin
      rraw[0] = bp[i][0];
      tk(1);
    end
    tk(10);

    // Release bounce while held: back to HELD, no second strobe
    k = cyc;
    sraw[0] = 1'b0;
    ex(0, 0, 0, 0, k + 6);
    ex(0, 0, 1, 0, k + 6);
    tk(10);
    sraw[0] = 1'b1;
    tk(2);
    sraw[0] = 1'b0;
    tk(12);
    k = cyc;
    sraw[0] = 1'b1;
    ex(0, 0, 1, 1, k + 6);
    tk(10);

    // Simultaneous press on both channels
    k = cyc;
    sraw[0] = 1'b0;
    rraw[0] = 1'b0;
    ex(0, 0, 0, 0, k + 6);
    ex(0, 0, 1, 0, k + 6);
    ex(0, 1, 0, 0, k + 6);
    ex(0, 1, 1, 0, k + 6);
    tk(10);
    k = cyc;
    sraw[0] = 1'b1;
    rraw[0] = 1'b1;
    ex(0, 0, 1, 1, k + 6);
    ex(0, 1, 1, 1, k + 6);
    tk(10);

    // Sync 3 / debounce 2: press plus a 1-cycle glitch on the other channel
    k = cyc;
    sraw[1] = 1'b0;
    ex(1, 0, 0, 0, k + 5);
    ex(1, 0, 1, 0, k + 5);
    tk(1);
    rraw[1] = 1'b0;
    tk(1);
    rraw[1] = 1'b1;
    tk(10);
    k = cyc;
    sraw[1] = 1'b1;
    ex(1, 0, 1, 1, k + 5);
    tk(10);

    mon_en = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d unmatched, required 0 (first dut%0d ch%0d kind%0d edge %0d)",
               exp_q.size(), exp_q[0].dut, exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_ctrl.md
# btn_debounce_ctrl

Two-channel pushbutton conditioner that turns raw, asynchronous, bouncing active-low buttons into clean, clock-synchronous, active-low control strobes. It sits directly upstream of the flip-flop stage and drives its `set_n`/`reset_n` data-path controls. The flip-flop then sees only single-cycle, glitch-free requests and never receives metastable or bouncing inputs.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth per channel; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to confirm press or release; legal range 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width; derived, not overridden.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `btn_set_raw_n`  in  1  raw set button, active-low, asynchronous to `clk`.
- `btn_reset_raw_n`  in  1  raw reset button, active-low, asynchronous.
- `ff_set_n`  out  1  registered one-cycle low strobe on a confirmed set press.
- `ff_reset_n`  out  1  registered one-cycle low strobe on a confirmed reset press.
- `set_held_n`  out  1  registered level; low while the set button is debounced-pressed.
- `reset_held_n`  out  1  registered level; low while the reset button is debounced-pressed.

## Operation
- Both channels are identical and fully independent. No cross-channel priority is applied; simultaneous strobes are both emitted, and the downstream flip-flop resolves them (reset wins).
- Per channel, a `SYNC_STAGES`-deep flop chain feeds the synchronized sample `s` (0 = pressed).
- FSM states:
  - IDLE: `s`=0 -> PRESS_WAIT, cnt=1. Otherwise stay, cnt=0.
  - PRESS_WAIT: `s`=1 -> IDLE, cnt=0. `s`=0 with cnt+1==DEBOUNCE_CYCLES -> HELD, cnt=0, strobe low for the next cycle. Otherwise cnt+1.
  - HELD: `s`=1 -> RELEASE_WAIT, cnt=1. Otherwise stay.
  - RELEASE_WAIT: `s`=0 -> HELD, cnt=0, no new strobe. `s`=1 with cnt+1==DEBOUNCE_CYCLES -> IDLE, cnt=0. Otherwise cnt+1.
- Strobe fires only on the PRESS_WAIT->HELD transition. Release never produces a strobe.
- `*_held_n` is 0 in HELD and RELEASE_WAIT, and 1 in IDLE and PRESS_WAIT.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset values: synchronizer flops 1, state IDLE, cnt 0, all four outputs 1.
- Reset asserted mid-press: everything returns to reset values. If the button is still held after reset releases, the press is re-detected and a new strobe is emitted after full latency.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Raw input low and stable before edge E0, bounce-free: strobe is registered low at edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1 and back to 1 at the following edge. With defaults, it is low between edges E0+5 and E0+6.
- `*_held_n` falls at the same edge as the strobe.
- `*_held_n` rises at edge R0+SYNC_STAGES+DEBOUNCE_CYCLES-1, where R0 is the first edge sampling the released input.
- Any bounce shorter than DEBOUNCE_CYCLES synchronized samples produces no strobe and no change in the held level.
- A held button yields exactly one strobe, regardless of hold duration.

## Structure
- Shared package/header holds:
  - the 2-bit state encodings IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3;
  - the default SYNC_STAGES and DEBOUNCE_CYCLES constants.
- Sub-module `debounce_ch` (one synchronizer, one FSM, one counter, strobe and held outputs) is instantiated twice. The top level contains only wiring.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with both buttons low -> all outputs 1, both FSMs IDLE. Release reset with buttons still low -> one strobe per channel, at cycle 5 after release.
- Clean press: `btn_set_raw_n` driven 0 before edge E0 and held for 20 cycles -> `ff_set_n`=0 only between edges E0+5 and E0+6. `set_held_n`=0 from E0+5 until 5 edges after release is sampled. `ff_reset_n` stays 1.
- Bounce rejection: `btn_reset_raw_n` pattern 0,0,0,1,0,0,1 (one value per cycle), then 1 -> no strobe, `reset_held_n` stays 1.
- Release bounce: while in HELD, drive 1,1,0 then steady 0 -> state returns to HELD, no second strobe, `set_held_n` stays 0 throughout.
- Simultaneous: both raw inputs fall before the same edge E0 -> `ff_set_n` and `ff_reset_n` both 0 in the same cycle, between edges E0+5 and E0+6.
- Parameter sweep: DEBOUNCE_CYCLES=2 and SYNC_STAGES=3 -> strobe at edge E0+4. A 1-cycle glitch is rejected.
